mem_access_stage: RTL

Memory-access stage of the RISC-V core, directly downstream of the execute-stage ALU. It takes the ALU result as an effective address and runs a request/grant/response handshake with the data memory. It generates byte enables and shifted store data, then aligns and sign-extends load data. It hands one registered result per instruction to writeback; non-memory instructions pass through with fixed one-cycle latency.

---
 rtl/mem_access_stage_pkg.sv | 64 ++++++
 rtl/mem_access_stage_load_align.sv | 33 +++
 rtl/mem_access_stage.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// ============================================================================
// mem_access_stage_pkg : funct3 encodings, FSM states and access-size helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_access_stage_pkg;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam logic [2:0] FNC_SB  = 3'b000;
    localparam logic [2:0] FNC_SH  = 3'b001;
    localparam logic [2:0] FNC_SW  = 3'b010;

    typedef enum logic [1:0] {
        MEM_STATE_IDLE = 2'd0,
        MEM_STATE_REQ  = 2'd1,
        MEM_STATE_RESP = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_e;

    // Unsupported funct3 values fall back to full-word accesses.
    function automatic access_size_e access_size(input logic [2:0] funct3,
                                                 input logic       is_store);
        access_size_e sz;
        sz = SZ_WORD;
        if (is_store) begin
            case (funct3)
                FNC_SB:  sz = SZ_BYTE;
                FNC_SH:  sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (funct3)
                FNC_LB, FNC_LBU: sz = SZ_BYTE;
                FNC_LH, FNC_LHU: sz = SZ_HALF;
                default:         sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(input access_size_e sz,
                                           input logic [1:0]   off);
        logic mis;
        case (sz)
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_stage_load_align.sv
// ============================================================================
// load_align : selects the byte/half at the access offset and extends it
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_align
    import mem_access_stage_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        offset_i,
    input  logic [DWIDTH-1:0] rdata_i,
    output logic [DWIDTH-1:0] data_o
);

    logic [DWIDTH-1:0] shifted;

    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        case (funct3_i)
            FNC_LB:  data_o = {{(DWIDTH-8){shifted[7]}}, shifted[7:0]};
            FNC_LBU: data_o = {{(DWIDTH-8){1'b0}}, shifted[7:0]};
            FNC_LH:  data_o = {{(DWIDTH-16){shifted[15]}}, shifted[15:0]};
            FNC_LHU: data_o = {{(DWIDTH-16){1'b0}}, shifted[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// mem_access_stage : RISC-V memory-access stage with req/gnt/rvalid handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DWIDTH-1:0] ex_alu_out,
    input  logic [DWIDTH-1:0] ex_store_data,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_we,
    output logic              dmem_req,
    output logic [DWIDTH-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DWIDTH-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DWIDTH-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_we,
    output logic [DWIDTH-1:0] wb_data,
    output logic              wb_misaligned
);

    mem_state_e        state_q, state_d;
    logic [DWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic              we_q, we_d;
    logic              is_load_q, is_load_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_we_q, wb_we_d;
    logic [DWIDTH-1:0] wb_data_q, wb_data_d;
    logic              wb_mis_q, wb_mis_d;

    access_size_e      ex_size;
    logic              ex_is_mem;
    logic              ex_mis;
    logic [3:0]        st_be;
    logic [DWIDTH-1:0] st_wdata;
    logic [DWIDTH-1:0] ld_data;

    always_comb begin
        ex_size   = access_size(ex_funct3, ex_is_store);
        ex_is_mem = ex_is_load | ex_is_store;
        ex_mis    = ex_is_mem & is_misaligned(ex_size, ex_alu_out[1:0]);
        case (ex_size)
            SZ_BYTE: begin
                st_be    = 4'b0001 << ex_alu_out[1:0];
                st_wdata = {4{ex_store_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = 4'b0011 << ex_alu_out[1:0];
                st_wdata = {2{ex_store_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = ex_store_data;
            end
        endcase
    end

    load_align #(
        .DWIDTH   (DWIDTH)
    ) u_load_align (
        .funct3_i (f3_q),
        .offset_i (addr_q[1:0]),
        .rdata_i  (dmem_rdata),
        .data_o   (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        we_d       = we_q;
        is_load_d  = is_load_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_we_d    = wb_we_q;
        wb_data_d  = wb_data_q;
        wb_mis_d   = wb_mis_q;
        case (state_q)
            MEM_STATE_IDLE: begin
                if (ex_valid) begin
                    if (!ex_is_mem || ex_mis) begin
                        // Pass-through and misaligned ops both report the address/ALU value.
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ex_rd;
                        wb_we_d    = ex_is_mem ? 1'b0 : ex_reg_we;
                        wb_data_d  = ex_alu_out;
                        wb_mis_d   = ex_mis;
                    end else begin
                        state_d   = MEM_STATE_REQ;
                        addr_d    = ex_alu_out;
                        wdata_d   = st_wdata;
                        be_d      = ex_is_store ? st_be : 4'b0000;
                        f3_d      = ex_funct3;
                        rd_d      = ex_rd;
                        we_d      = ex_reg_we;
                        is_load_d = ex_is_load;
                    end
                end
            end
            MEM_STATE_REQ: begin
                if (dmem_gnt) begin
                    if (is_load_q) begin
                        state_d = MEM_STATE_RESP;
                    end else begin
                        state_d    = MEM_STATE_IDLE;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_we_d    = 1'b0;
                        wb_data_d  = '0;
                        wb_mis_d   = 1'b0;
                    end
                end
            end
            MEM_STATE_RESP: begin
                if (dmem_rvalid) begin
                    state_d    = MEM_STATE_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_we_d    = we_q;
                    wb_data_d  = ld_data;
                    wb_mis_d   = 1'b0;
                end
            end
            default: state_d = MEM_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MEM_STATE_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= 4'b0000;
            f3_q       <= 3'b000;
            rd_q       <= 5'd0;
            we_q       <= 1'b0;
            is_load_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_we_q    <= 1'b0;
            wb_data_q  <= '0;
            wb_mis_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            is_load_q  <= is_load_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_we_q    <= wb_we_d;
            wb_data_q  <= wb_data_d;
            wb_mis_q   <= wb_mis_d;
        end
    end

    // Decoded straight from the state register so reset drops the request asynchronously.
    assign ex_ready      = (state_q == MEM_STATE_IDLE);
    assign dmem_req      = (state_q == MEM_STATE_REQ);
    assign dmem_addr     = {addr_q[DWIDTH-1:2], 2'b00};
    assign dmem_be       = be_q;
    assign dmem_wdata    = wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_we         = wb_we_q;
    assign wb_data       = wb_data_q;
    assign wb_misaligned = wb_mis_q;

endmodule

`default_nettype wire
